lsu_mem_if: RTL and testbench

- Load/store unit front end for the 5-stage RV32I core. It is the initiator side of the data-memory port.
- Accepts one load/store per request from the execute/memory stage and checks alignment.
- Drives the data-memory request fields (data_req, address, wdata, operator) and waits for the memory grant.
- Returns sign- or zero-extended load data with a destination-register tag, and holds a stall while an access is outstanding.

---
 rtl/lsu_mem_if.sv | 227 ++++++++++++++++++++++
 tb/tb_lsu_mem_if.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mem_if (with core_pkg)
//  Purpose  : Load/store unit front end for the 5-stage RV32I core.
//             Accepts one access at a time and checks its alignment.
//             Drives the data-memory request and waits for the grant,
//             with a timeout. Returns extended load data with its
//             destination tag.
//  Revision : 1.0 - initial release
// ============================================================================

package core_pkg;
  // Loads first so that the reset operator (LW) encodes as zero
  typedef enum logic [2:0] {
    LW  = 3'd0,
    LH  = 3'd1,
    LHU = 3'd2,
    LB  = 3'd3,
    LBU = 3'd4,
    SW  = 3'd5,
    SH  = 3'd6,
    SB  = 3'd7
  } load_store_func_code;
endpackage

module lsu_mem_if
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                clock,
  input  logic                reset,
  // pipeline side
  input  logic                lsu_req_ip,
  input  load_store_func_code lsu_operator_ip,
  input  logic [31:0]         addr_ip,
  input  logic [31:0]         wdata_ip,
  input  logic [4:0]          rd_ip,
  output logic                lsu_ready_op,
  // data memory side
  output logic                data_req_op,
  output logic [31:0]         data_addr_op,
  output logic [31:0]         wdata_op,
  output load_store_func_code lsu_operator_op,
  input  logic                mem_gnt_ip,
  input  logic [31:0]         load_data_ip,
  // results
  output logic                load_valid_op,
  output logic [31:0]         load_data_op,
  output logic [4:0]          load_rd_op,
  output logic                store_done_op,
  output logic                misaligned_op,
  output logic                bus_err_op,
  output logic [31:0]         fault_addr_op
);

  // Counter value on the edge at which a missing grant becomes a timeout:
  // it has then seen TIMEOUT_CYCLES REQ edges without a grant.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_RESP  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t              state_q;
  state_t              state_nx;

  // Captured request
  load_store_func_code op_q;
  logic [31:0]         addr_q;
  logic [31:0]         wdata_q;
  logic [4:0]          rd_q;

  logic [CNT_W-1:0]    cnt_q;
  // Distinguishes the two kinds of FAULT visit: 1 = misaligned, 0 = bus error
  logic                fault_mis_q;

  logic [31:0]         load_data_q;
  logic [4:0]          load_rd_q;
  logic [31:0]         fault_addr_q;

  logic                accept;
  logic                align_err;
  logic                timeout_hit;
  logic                cur_is_load;
  logic [31:0]         load_ext;

  // Classify an operator as a load (loads return data, stores only complete)
  function automatic logic is_load(input load_store_func_code op);
    case (op)
      LW, LH, LHU, LB, LBU: is_load = 1'b1;
      default:              is_load = 1'b0;
    endcase
  endfunction

  // Alignment of the incoming request, judged on its own operator and address
  always_comb begin
    align_err = 1'b0;
    case (lsu_operator_ip)
      LW, SW:      align_err = (addr_ip[1:0] != 2'b00);
      LH, LHU, SH: align_err = addr_ip[0];
      default:     align_err = 1'b0;
    endcase
  end

  // Sign/zero extension of the returned word according to the captured operator
  always_comb begin
    load_ext = load_data_ip;
    case (op_q)
      LH:      load_ext = {{16{load_data_ip[15]}}, load_data_ip[15:0]};
      LHU:     load_ext = {16'h0000, load_data_ip[15:0]};
      LB:      load_ext = {{24{load_data_ip[7]}}, load_data_ip[7:0]};
      LBU:     load_ext = {24'h000000, load_data_ip[7:0]};
      default: load_ext = load_data_ip;
    endcase
  end

  assign accept      = (state_q == S_IDLE) && lsu_req_ip;
  assign timeout_hit = (state_q == S_REQ) && !mem_gnt_ip && (cnt_q == CNT_LAST);
  assign cur_is_load = is_load(op_q);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // Next-state decode and per-state outputs
  always_comb begin
    state_nx        = state_q;
    lsu_ready_op    = 1'b0;
    data_req_op     = 1'b0;
    data_addr_op    = 32'h0;
    wdata_op        = 32'h0;
    lsu_operator_op = LW;
    load_valid_op   = 1'b0;
    store_done_op   = 1'b0;
    misaligned_op   = 1'b0;
    bus_err_op      = 1'b0;
    case (state_q)
      S_IDLE: begin
        lsu_ready_op = 1'b1;
        if (lsu_req_ip) begin
          state_nx = align_err ? S_FAULT : S_REQ;
        end
      end
      S_REQ: begin
        data_req_op     = 1'b1;
        data_addr_op    = addr_q;
        wdata_op        = wdata_q;
        lsu_operator_op = op_q;
        // A grant on the expiry edge still wins over the timeout
        if (mem_gnt_ip) begin
          state_nx = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          state_nx = S_FAULT;
        end
      end
      S_RESP: begin
        load_valid_op = cur_is_load;
        store_done_op = !cur_is_load;
        state_nx      = S_IDLE;
      end
      S_FAULT: begin
        misaligned_op = fault_mis_q;
        bus_err_op    = !fault_mis_q;
        state_nx      = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Request capture, timeout counter, load result and fault address registers
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q         <= LW;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      rd_q         <= 5'd0;
      cnt_q        <= '0;
      fault_mis_q  <= 1'b0;
      load_data_q  <= 32'h0;
      load_rd_q    <= 5'd0;
      fault_addr_q <= 32'h0;
    end else begin
      if (accept) begin
        op_q        <= lsu_operator_ip;
        addr_q      <= addr_ip;
        wdata_q     <= wdata_ip;
        rd_q        <= rd_ip;
        cnt_q       <= '0;
        fault_mis_q <= align_err;
        if (align_err) begin
          fault_addr_q <= addr_ip;
        end
      end
      if (state_q == S_REQ) begin
        if (mem_gnt_ip) begin
          if (cur_is_load) begin
            load_data_q <= load_ext;
            load_rd_q   <= rd_q;
          end
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      if (timeout_hit) begin
        fault_mis_q  <= 1'b0;
        fault_addr_q <= addr_q;
      end
    end
  end

  assign load_data_op  = load_data_q;
  assign load_rd_op    = load_rd_q;
  assign fault_addr_op = fault_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_if.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_mem_if
//  Purpose  : Directed self-checking bench for lsu_mem_if (TIMEOUT_CYCLES=4)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_if;
  import core_pkg::*;

  logic                clock;
  logic                reset;
  logic                lsu_req_ip;
  load_store_func_code lsu_operator_ip;
  logic [31:0]         addr_ip;
  logic [31:0]         wdata_ip;
  logic [4:0]          rd_ip;
  logic                lsu_ready_op;
  logic                data_req_op;
  logic [31:0]         data_addr_op;
  logic [31:0]         wdata_op;
  load_store_func_code lsu_operator_op;
  logic                mem_gnt_ip;
  logic [31:0]         load_data_ip;
  logic                load_valid_op;
  logic [31:0]         load_data_op;
  logic [4:0]          load_rd_op;
  logic                store_done_op;
  logic                misaligned_op;
  logic                bus_err_op;
  logic [31:0]         fault_addr_op;

  int total = 0;
  int bad   = 0;

  lsu_mem_if #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
    .clock           (clock),
    .reset           (reset),
    .lsu_req_ip      (lsu_req_ip),
    .lsu_operator_ip (lsu_operator_ip),
    .addr_ip         (addr_ip),
    .wdata_ip        (wdata_ip),
    .rd_ip           (rd_ip),
    .lsu_ready_op    (lsu_ready_op),
    .data_req_op     (data_req_op),
    .data_addr_op    (data_addr_op),
    .wdata_op        (wdata_op),
    .lsu_operator_op (lsu_operator_op),
    .mem_gnt_ip      (mem_gnt_ip),
    .load_data_ip    (load_data_ip),
    .load_valid_op   (load_valid_op),
    .load_data_op    (load_data_op),
    .load_rd_op      (load_rd_op),
    .store_done_op   (store_done_op),
    .misaligned_op   (misaligned_op),
    .bus_err_op      (bus_err_op),
    .fault_addr_op   (fault_addr_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".load_valid"}, 32'(load_valid_op), 32'd0);
    chk({tag, ".store_done"}, 32'(store_done_op), 32'd0);
    chk({tag, ".misaligned"}, 32'(misaligned_op), 32'd0);
    chk({tag, ".bus_err"},    32'(bus_err_op),    32'd0);
  endtask

  task automatic start(input load_store_func_code op, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    lsu_req_ip      = 1'b1;
    lsu_operator_ip = op;
    addr_ip         = a;
    wdata_ip        = wd;
    rd_ip           = rd;
  endtask

  // Load granted in its first REQ cycle, result checked against a hand value
  task automatic load_imm(input string tag, input load_store_func_code op, input logic [31:0] a,
                          input logic [4:0] rd, input logic [31:0] mem, input logic [31:0] exp);
    start(op, a, 32'h0, rd);
    tick();
    chk({tag, ".req"},   32'(data_req_op), 32'd1);
    chk({tag, ".addr"},  data_addr_op, a);
    chk({tag, ".op"},    32'(lsu_operator_op), 32'(op));
    chk({tag, ".ready"}, 32'(lsu_ready_op), 32'd0);
    lsu_req_ip   = 1'b0;
    mem_gnt_ip   = 1'b1;
    load_data_ip = mem;
    tick();
    chk({tag, ".valid"}, 32'(load_valid_op), 32'd1);
    chk({tag, ".data"},  load_data_op, exp);
    chk({tag, ".rd"},    32'(load_rd_op), 32'(rd));
    chk({tag, ".req_off"}, 32'(data_req_op), 32'd0);
    mem_gnt_ip   = 1'b0;
    load_data_ip = 32'h0;
    tick();
    chk({tag, ".ready_back"}, 32'(lsu_ready_op), 32'd1);
    chk({tag, ".valid_off"},  32'(load_valid_op), 32'd0);
    chk({tag, ".data_hold"},  load_data_op, exp);
  endtask

  task automatic misaligned(input string tag, input load_store_func_code op, input logic [31:0] a);
    start(op, a, 32'hA5A5A5A5, 5'd3);
    tick();
    chk({tag, ".mis"},   32'(misaligned_op), 32'd1);
    chk({tag, ".faddr"}, fault_addr_op, a);
    chk({tag, ".req"},   32'(data_req_op), 32'd0);
    chk({tag, ".berr"},  32'(bus_err_op), 32'd0);
    chk({tag, ".ready"}, 32'(lsu_ready_op), 32'd0);
    lsu_req_ip = 1'b0;
    tick();
    chk({tag, ".ready_back"}, 32'(lsu_ready_op), 32'd1);
    chk({tag, ".req_after"},  32'(data_req_op), 32'd0);
    chk_quiet({tag, ".after"});
  endtask

  initial begin
    reset           = 1'b1;
    lsu_req_ip      = 1'b0;
    lsu_operator_ip = SB;
    addr_ip         = 32'h0;
    wdata_ip        = 32'h0;
    rd_ip           = 5'd0;
    mem_gnt_ip      = 1'b0;
    load_data_ip    = 32'h0;
    tick();
    tick();

    // Reset state
    chk("rst.ready", 32'(lsu_ready_op), 32'd1);
    chk("rst.req",   32'(data_req_op), 32'd0);
    chk("rst.addr",  data_addr_op, 32'h0);
    chk("rst.wdata", wdata_op, 32'h0);
    chk("rst.op",    32'(lsu_operator_op), 32'(LW));
    chk("rst.ldata", load_data_op, 32'h0);
    chk("rst.lrd",   32'(load_rd_op), 32'd0);
    chk("rst.faddr", fault_addr_op, 32'h0);
    chk_quiet("rst");
    reset = 1'b0;
    tick();

    // Loads with each extension kind
    load_imm("lw",  LW,  32'h10, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF);
    load_imm("lb",  LB,  32'h13, 5'd6,  32'h00000080, 32'hFFFFFF80);
    load_imm("lbu", LBU, 32'h13, 5'd7,  32'h00000080, 32'h00000080);
    load_imm("lh",  LH,  32'h12, 5'd8,  32'h00008001, 32'hFFFF8001);
    load_imm("lhu", LHU, 32'h12, 5'd9,  32'h00008001, 32'h00008001);

    // Store with grant on the 4th REQ edge (also the timeout boundary)
    start(SW, 32'h20, 32'h12345678, 5'd1);
    tick();
    lsu_req_ip = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("sw.req",   32'(data_req_op), 32'd1);
      chk("sw.addr",  data_addr_op, 32'h20);
      chk("sw.wdata", wdata_op, 32'h12345678);
      chk("sw.op",    32'(lsu_operator_op), 32'(SW));
      chk_quiet("sw.wait");
      if (i == 3) mem_gnt_ip = 1'b1;
      tick();
    end
    mem_gnt_ip = 1'b0;
    chk("sw.done",  32'(store_done_op), 32'd1);
    chk("sw.valid", 32'(load_valid_op), 32'd0);
    chk("sw.berr",  32'(bus_err_op), 32'd0);
    chk("sw.req_off", 32'(data_req_op), 32'd0);
    chk("sw.addr_off", data_addr_op, 32'h0);
    tick();
    chk("sw.done_off", 32'(store_done_op), 32'd0);
    chk("sw.ready",    32'(lsu_ready_op), 32'd1);
    chk("sw.ldata_hold", load_data_op, 32'h00008001);

    // Misaligned accesses, then an aligned halfword at the same word
    misaligned("mis_lw", LW, 32'h22);
    misaligned("mis_sh", SH, 32'h21);
    load_imm("lh22", LH, 32'h22, 5'd10, 32'h00001234, 32'h00001234);
    chk("lh22.faddr_hold", fault_addr_op, 32'h21);

    // Timeout: 4 REQ cycles with no grant, then bus error
    start(LW, 32'h40, 32'h0, 5'd11);
    tick();
    lsu_req_ip = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to.req", 32'(data_req_op), 32'd1);
      chk_quiet("to.wait");
      tick();
    end
    chk("to.berr",  32'(bus_err_op), 32'd1);
    chk("to.faddr", fault_addr_op, 32'h40);
    chk("to.mis",   32'(misaligned_op), 32'd0);
    chk("to.valid", 32'(load_valid_op), 32'd0);
    chk("to.req_off", 32'(data_req_op), 32'd0);
    tick();
    chk("to.ready",    32'(lsu_ready_op), 32'd1);
    chk("to.berr_off", 32'(bus_err_op), 32'd0);
    chk("to.ldata_hold", load_data_op, 32'h00001234);

    // Load granted exactly on the 4th REQ edge completes normally
    start(LW, 32'h44, 32'h0, 5'd12);
    tick();
    lsu_req_ip = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("g4.req", 32'(data_req_op), 32'd1);
      if (i == 3) begin
        mem_gnt_ip   = 1'b1;
        load_data_ip = 32'hCAFEF00D;
      end
      tick();
    end
    mem_gnt_ip   = 1'b0;
    load_data_ip = 32'h0;
    chk("g4.valid", 32'(load_valid_op), 32'd1);
    chk("g4.data",  load_data_op, 32'hCAFEF00D);
    chk("g4.rd",    32'(load_rd_op), 32'd12);
    chk("g4.berr",  32'(bus_err_op), 32'd0);
    tick();
    chk("g4.ready", 32'(lsu_ready_op), 32'd1);

    // Reset in the middle of REQ drops the access
    start(LW, 32'h50, 32'h0, 5'd13);
    tick();
    lsu_req_ip = 1'b0;
    chk("rmid.req", 32'(data_req_op), 32'd1);
    reset = 1'b1;
    tick();
    chk("rmid.req_off", 32'(data_req_op), 32'd0);
    chk("rmid.ready",   32'(lsu_ready_op), 32'd1);
    chk_quiet("rmid.r");
    reset = 1'b0;
    tick();
    chk_quiet("rmid.p1");
    chk("rmid.req_p1", 32'(data_req_op), 32'd0);
    tick();
    chk_quiet("rmid.p2");
    load_imm("post", LW, 32'h54, 5'd14, 32'h0BADCAFE, 32'h0BADCAFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
